cpu_debug_ocimem_arbiter: RTL and testbench
===========================================

# cpu_debug_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM: monitor code and data) between two requesters. One is the JTAG debug module's system-clock command strobes (the `take_*_ocimem_*` pulses with `jdo`). The other is the CPU's Avalon-MM debug slave port. It sequences single-port RAM accesses with round-robin fairness and returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG side. It sits between the JTAG debug module wrapper and the OCI RAM instance inside the CPU top.

## Interface
Parameters:
- `ADDR_W`, 8: OCI RAM word-address width (256 words).
- `DATA_W`, 32: data width. It is fixed by the `jdo` layout, so 32 is the only legal value.

Ports:
- `clk` in 1: system clock, the same domain as the `jdo`/`take_*` strobes.
- `reset` in 1: asynchronous, active-high reset.
- `jdo` in 38: JTAG data-out register.
- `take_action_ocimem_a` in 1: JTAG command "load address"; may also queue a read.
- `take_no_action_ocimem_a` in 1: JTAG command "read at current address".
- `take_action_ocimem_b` in 1: JTAG command "write at current address".
- `MonDReg` out 32: last JTAG read data, or last JTAG write data.
- `monitor_ready` out 1: no JTAG command pending or in service.
- `monitor_error` out 1: sticky flag; a JTAG command was dropped because it arrived while busy.
- `avs_address` in ADDR_W: CPU word address.
- `avs_read`, `avs_write` in 1: CPU read / write request.
- `avs_writedata` in 32: CPU write data.
- `avs_byteenable` in 4: CPU byte enables.
- `avs_debugaccess` in 1: CPU write permission.
- `avs_readdata` out 32: CPU read data.
- `avs_waitrequest` out 1: Avalon wait.
- `ram_addr` out ADDR_W, `ram_wr` out 1, `ram_wdata` out 32, `ram_be` out 4: RAM control.
- `ram_rddata` in 32: RAM read data, registered, 1-cycle latency.

## Operation
JTAG command decode (`jdo` fields):
- `take_action_ocimem_a`: `jtag_addr <= jdo[33:26]` and `monitor_error <= 0`. If `jdo[25]`=1, also queue a read at the new address.
- `take_no_action_ocimem_a`: queue a read at `jtag_addr`.
- `take_action_ocimem_b`: queue a write of `jdo[34:3]` at `jtag_addr`, with `be=4'hF`.
- Each completed JTAG read or write post-increments `jtag_addr`, wrapping modulo 2^ADDR_W.
- JTAG queue is one deep. `jtag_busy = pend_valid | (FSM serving JTAG)`.
  - A queuing strobe while `jtag_busy` is dropped and sets `monitor_error`.
  - An address load while busy still updates `jtag_addr`.
- `monitor_ready = ~jtag_busy` (registered).
- Only one strobe is asserted per cycle. If more than one is asserted, priority is `action_ocimem_a` > `action_ocimem_b` > `no_action_ocimem_a`.

CPU side:
- A request is `avs_read | avs_write`. If both are high, it is treated as a read.
- A write with `avs_debugaccess`=0 completes normally, but `ram_wr` stays 0.

Arbitration:
- Evaluated only in IDLE.
- If one side requests, that side is granted.
- If both request, the side not granted last time wins (`last_grant` resets to CPU, so JTAG wins the first tie).

FSM:
- IDLE: on grant, register `ram_addr`/`ram_wdata`/`ram_be` and go to ACCESS.
- ACCESS:
  - Write: `ram_wr`=1, complete, return to IDLE.
  - Read: go to RD_WAIT.
- RD_WAIT: `ram_rddata` is valid. Complete: JTAG loads `MonDReg`; CPU gets `avs_readdata = ram_rddata`. Return to IDLE.
- On JTAG write completion, `MonDReg <= write data`.

## Timing
Reset values:
- `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0.
- `avs_waitrequest`=1, `avs_readdata`=0.
- `ram_wr`=0, `ram_addr`=0, `ram_wdata`=0, `ram_be`=0.
- `jtag_addr`=0, `pend_valid`=0, state IDLE.

Latency:
- `avs_waitrequest` stays 1 except in the completion cycle of the CPU's own access.
- CPU write, request seen in IDLE at cycle 0: `waitrequest`=0 at cycle 1 (ACCESS, `ram_wr`=1).
- CPU read, request at cycle 0: `waitrequest`=0 at cycle 2, with `avs_readdata` valid in that cycle.
- JTAG strobe at cycle 0: `pend_valid` at cycle 1. If granted at cycle 1, ACCESS is at cycle 2.
  - Read: RD_WAIT at cycle 3, `MonDReg` updated and `monitor_ready`=1 from cycle 4.
  - Write: `monitor_ready`=1 from cycle 3.
- `monitor_ready` falls in the cycle after the accepting strobe.

Boundary cases:
- A strobe in the same cycle a JTAG completion occurs is accepted, because the busy term is cleared by the completion.
- Address 255 increments to 0.
- Reset asserted mid-access returns to IDLE immediately, with no RAM write and the pending command discarded.
- The CPU must hold its request until `waitrequest`=0. A CPU request withdrawn while waiting is not served if still in IDLE; if already in ACCESS or RD_WAIT, the access completes.

## Structure
- Shared package `cpu_debug_pkg`:
  - state enum {IDLE, ACCESS, RD_WAIT};
  - `jdo` field constants `JDO_ADDR_HI`=33, `JDO_ADDR_LO`=26, `JDO_RDREQ`=25, `JDO_WDATA_HI`=34, `JDO_WDATA_LO`=3.
- One sub-module `dbg_rr_arb2`: 2-requester round-robin arbiter with `last_grant` state.

## Test plan
- JTAG write then read: `ocimem_a` with addr 0x10, then `ocimem_b` with data 0xDEADBEEF, then `ocimem_a` with addr 0x10 and `jdo[25]`=1 -> RAM[0x10]=0xDEADBEEF; `MonDReg`=0xDEADBEEF; `jtag_addr`=0x11.
- CPU read at address 0x20, where RAM holds 0x12345678 -> `waitrequest` low exactly at cycle 2, `avs_readdata`=0x12345678; CPU write without `debugaccess` -> `ram_wr` never 1.
- Simultaneous first JTAG and CPU requests -> JTAG served first, CPU next. Sustained contention -> grants strictly alternate.
- Second `no_action_ocimem_a` one cycle after the first -> `monitor_error`=1 and only one read performed; next `ocimem_a` clears the error.
- `jtag_addr`=0xFF with a write -> `jtag_addr` wraps to 0x00.
- Reset asserted during RD_WAIT -> all outputs at reset values the next cycle; no `MonDReg` update.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared types and jdo field positions for the Nios II debug OCI RAM arbiter.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_RDREQ    = 25;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;

endpackage

// File: rtl/dbg_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side not granted last time wins.
module dbg_rr_arb2
  import cpu_debug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req_jtag,
  input  logic i_req_cpu,
  output logic o_gnt_jtag,
  output logic o_gnt_cpu
);

  grant_e r_last_grant;

  always_comb begin
    // NOTE: both grants get a default before any branch so no path leaves them unassigned (no latch).
    o_gnt_jtag = 1'b0;
    o_gnt_cpu  = 1'b0;
    if (i_en) begin
      if (i_req_jtag && i_req_cpu) begin
        o_gnt_jtag = (r_last_grant == GNT_CPU);
        o_gnt_cpu  = (r_last_grant == GNT_JTAG);
      end else begin
        o_gnt_jtag = i_req_jtag;
        o_gnt_cpu  = i_req_cpu;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= GNT_CPU;
    end else if (o_gnt_jtag) begin
      r_last_grant <= GNT_JTAG;
    end else if (o_gnt_cpu) begin
      r_last_grant <= GNT_CPU;
    end
  end

endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG command strobes and the CPU
// Avalon debug slave, sequencing IDLE -> ACCESS (-> RD_WAIT) per access.
module cpu_debug_ocimem_arbiter
  import cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rddata
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_jtag_addr;
  logic                r_pend_valid;
  logic                r_pend_wr;
  logic [DATA_W-1:0]   r_pend_wdata;
  logic                r_acc_jtag;
  logic                r_acc_wr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [3:0]          r_ram_be;
  logic [DATA_W-1:0]   r_mon_dreg;
  logic                r_monitor_ready;
  logic                r_monitor_error;
  logic                r_avs_waitrequest;

  logic w_cpu_req, w_cpu_wr;
  logic w_jtag_done, w_jtag_busy, w_accept_ok;
  logic w_q_rd_a, w_q_wr, w_q_rd_n, w_queue, w_accept, w_drop;
  logic w_gnt_jtag, w_gnt_cpu;
  logic w_pend_next, w_jtag_svc_next;
  logic w_unused_jdo;

  assign w_cpu_req = avs_read | avs_write;
  assign w_cpu_wr  = avs_write & ~avs_read;

  // A completing JTAG access frees the queue in the same cycle, so a strobe then is accepted.
  assign w_jtag_done = r_acc_jtag &
                       (((r_state == ACCESS) & r_acc_wr) | (r_state == RD_WAIT));
  assign w_jtag_busy = r_pend_valid | (r_acc_jtag & (r_state != IDLE));
  assign w_accept_ok = ~w_jtag_busy | w_jtag_done;

  assign w_q_rd_a = take_action_ocimem_a & jdo[JDO_RDREQ];
  assign w_q_wr   = ~take_action_ocimem_a & take_action_ocimem_b;
  assign w_q_rd_n = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
  assign w_queue  = w_q_rd_a | w_q_wr | w_q_rd_n;
  assign w_accept = w_queue & w_accept_ok;
  assign w_drop   = w_queue & ~w_accept_ok;

  assign w_pend_next     = w_accept | (r_pend_valid & ~w_gnt_jtag);
  assign w_jtag_svc_next = w_gnt_jtag | ((r_state == ACCESS) & ~r_acc_wr & r_acc_jtag);

  assign w_unused_jdo = ^{jdo[37:35], jdo[2:0]};

  dbg_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_state == IDLE),
    .i_req_jtag (r_pend_valid),
    .i_req_cpu  (w_cpu_req),
    .o_gnt_jtag (w_gnt_jtag),
    .o_gnt_cpu  (w_gnt_cpu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= IDLE;
      r_jtag_addr       <= '0;
      r_pend_valid      <= 1'b0;
      r_pend_wr         <= 1'b0;
      r_pend_wdata      <= '0;
      r_acc_jtag        <= 1'b0;
      r_acc_wr          <= 1'b0;
      r_ram_addr        <= '0;
      r_ram_wr          <= 1'b0;
      r_ram_wdata       <= '0;
      r_ram_be          <= '0;
      r_mon_dreg        <= '0;
      r_monitor_ready   <= 1'b1;
      r_monitor_error   <= 1'b0;
      r_avs_waitrequest <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge state.
      r_ram_wr          <= 1'b0;
      r_avs_waitrequest <= 1'b1;
      r_pend_valid      <= w_pend_next;
      r_monitor_ready   <= ~(w_pend_next | w_jtag_svc_next);

      if (w_accept) begin
        r_pend_wr    <= w_q_wr;
        r_pend_wdata <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
      end

      if (take_action_ocimem_a) begin
        r_jtag_addr <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      end else if (w_jtag_done) begin
        r_jtag_addr <= r_jtag_addr + 1'b1;
      end

      if (w_drop) begin
        r_monitor_error <= 1'b1;
      end else if (take_action_ocimem_a) begin
        r_monitor_error <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_gnt_jtag) begin
            r_ram_addr  <= r_jtag_addr;
            r_ram_wdata <= r_pend_wdata;
            r_ram_be    <= 4'hF;
            r_ram_wr    <= r_pend_wr;
            r_acc_jtag  <= 1'b1;
            r_acc_wr    <= r_pend_wr;
            r_state     <= ACCESS;
          end else if (w_gnt_cpu) begin
            r_ram_addr        <= avs_address;
            r_ram_wdata       <= avs_writedata;
            r_ram_be          <= avs_byteenable;
            r_ram_wr          <= w_cpu_wr & avs_debugaccess;
            r_acc_jtag        <= 1'b0;
            r_acc_wr          <= w_cpu_wr;
            r_avs_waitrequest <= ~w_cpu_wr;
            r_state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_acc_wr) begin
            if (r_acc_jtag) r_mon_dreg <= r_ram_wdata;
            r_state <= IDLE;
          end else begin
            if (!r_acc_jtag) r_avs_waitrequest <= 1'b0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_acc_jtag) r_mon_dreg <= ram_rddata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM data arrives only in RD_WAIT, so the CPU read path is a gated pass-through.
  assign avs_readdata    = ((r_state == RD_WAIT) && !r_acc_jtag) ? ram_rddata : '0;
  assign avs_waitrequest = r_avs_waitrequest;
  assign MonDReg         = r_mon_dreg;
  assign monitor_ready   = r_monitor_ready;
  assign monitor_error   = r_monitor_error;
  assign ram_addr        = r_ram_addr;
  assign ram_wr          = r_ram_wr;
  assign ram_wdata       = r_ram_wdata;
  assign ram_be          = r_ram_be;

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Directed bench for cpu_debug_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_cpu_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write, avs_debugaccess;
  logic [31:0] avs_writedata, avs_readdata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata, ram_rddata;
  logic [3:0]  ram_be;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cpu_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_be                  (ram_be),
    .ram_rddata              (ram_rddata)
  );

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rddata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic rd);
    jdo = (38'(a) << 26) | (38'(rd) << 25);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = 38'(d) << 3;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_n();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int max_cycles);
    int k = 0;
    while (!monitor_ready && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, 32'(monitor_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mondreg"}, MonDReg, 32'h0);
    check({tag, "_ready"},   32'(monitor_ready), 32'd1);
    check({tag, "_error"},   32'(monitor_error), 32'd0);
    check({tag, "_waitreq"}, 32'(avs_waitrequest), 32'd1);
    check({tag, "_rdata"},   avs_readdata, 32'h0);
    check({tag, "_ram_wr"},  32'(ram_wr), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    check({tag, "_ram_be"},  32'(ram_be), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    avs_byteenable = '0; avs_debugaccess = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    tick(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    preload(8'h11, 32'hA5A5_0011);
    preload(8'h20, 32'h1234_5678);
    preload(8'h21, 32'h1111_2222);
    preload(8'h30, 32'h3030_3030);
    preload(8'h31, 32'h3131_3131);
    preload(8'h40, 32'h4040_4040);

    // JTAG write 0xDEADBEEF at 0x10, read it back, then read the auto-incremented 0x11.
    jtag_a(8'h10, 1'b0);
    check("addr_load_ready", 32'(monitor_ready), 32'd1);
    jtag_b(32'hDEAD_BEEF);
    check("jwr_c1_ready", 32'(monitor_ready), 32'd0);
    tick();
    check("jwr_c2_ram_wr", 32'(ram_wr), 32'd1);
    check("jwr_c2_ram_addr", 32'(ram_addr), 32'h10);
    check("jwr_c2_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("jwr_c2_ram_be", 32'(ram_be), 32'hF);
    tick();
    check("jwr_c3_ready", 32'(monitor_ready), 32'd1);
    check("jwr_c3_mondreg", MonDReg, 32'hDEAD_BEEF);
    check("jwr_mem10", mem[8'h10], 32'hDEAD_BEEF);
    jtag_a(8'h10, 1'b1);
    check("jrd_c1_ready", 32'(monitor_ready), 32'd0);
    tick(2);
    check("jrd_c3_ready", 32'(monitor_ready), 32'd0);
    tick();
    check("jrd_c4_ready", 32'(monitor_ready), 32'd1);
    check("jrd_c4_mondreg", MonDReg, 32'hDEAD_BEEF);
    jtag_n();
    tick();
    check("jrd_inc_addr", 32'(ram_addr), 32'h11);
    tick(2);
    check("jrd_inc_ready", 32'(monitor_ready), 32'd1);
    check("jrd_inc_mondreg", MonDReg, 32'hA5A5_0011);

    // CPU read latency, write without and with debugaccess.
    avs_address = 8'h20; avs_read = 1'b1;
    tick();
    check("crd_c1_waitreq", 32'(avs_waitrequest), 32'd1);
    tick();
    check("crd_c2_waitreq", 32'(avs_waitrequest), 32'd0);
    check("crd_c2_rdata", avs_readdata, 32'h1234_5678);
    avs_read = 1'b0;
    tick();
    check("crd_c3_waitreq", 32'(avs_waitrequest), 32'd1);
    check("crd_c3_rdata", avs_readdata, 32'h0);
    avs_address = 8'h20; avs_writedata = 32'hFFFF_FFFF; avs_byteenable = 4'hF;
    avs_debugaccess = 1'b0; avs_write = 1'b1;
    tick();
    check("cwr_nodbg_waitreq", 32'(avs_waitrequest), 32'd0);
    check("cwr_nodbg_ram_wr", 32'(ram_wr), 32'd0);
    avs_write = 1'b0;
    tick();
    check("cwr_nodbg_mem20", mem[8'h20], 32'h1234_5678);
    avs_address = 8'h21; avs_writedata = 32'hCAFE_BABE; avs_byteenable = 4'b0011;
    avs_debugaccess = 1'b1; avs_write = 1'b1;
    tick();
    check("cwr_dbg_waitreq", 32'(avs_waitrequest), 32'd0);
    check("cwr_dbg_ram_wr", 32'(ram_wr), 32'd1);
    avs_write = 1'b0;
    tick();
    check("cwr_dbg_mem21", mem[8'h21], 32'h1111_BABE);

    // Contention from a fresh reset: JTAG wins the first tie, then grants alternate.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    jtag_b(32'h0000_D000);
    avs_address = 8'h20; avs_read = 1'b1;
    check("arb_c1_ready", 32'(monitor_ready), 32'd0);
    tick();
    check("arb_c2_jtag_addr", 32'(ram_addr), 32'h00);
    check("arb_c2_jtag_wr", 32'(ram_wr), 32'd1);
    check("arb_c2_waitreq", 32'(avs_waitrequest), 32'd1);
    jtag_b(32'h0000_D001);
    check("arb_c3_waitreq", 32'(avs_waitrequest), 32'd1);
    check("arb_c3_ready", 32'(monitor_ready), 32'd0);
    tick();
    check("arb_c4_cpu_addr", 32'(ram_addr), 32'h20);
    check("arb_c4_ram_wr", 32'(ram_wr), 32'd0);
    tick();
    check("arb_c5_waitreq", 32'(avs_waitrequest), 32'd0);
    check("arb_c5_rdata", avs_readdata, 32'h1234_5678);
    tick();
    check("arb_c6_waitreq", 32'(avs_waitrequest), 32'd1);
    tick();
    check("arb_c7_jtag_addr", 32'(ram_addr), 32'h01);
    check("arb_c7_jtag_wdata", ram_wdata, 32'h0000_D001);
    avs_read = 1'b0;
    tick();
    check("arb_c8_ready", 32'(monitor_ready), 32'd1);
    check("arb_mem00", mem[8'h00], 32'h0000_D000);
    check("arb_mem01", mem[8'h01], 32'h0000_D001);
    tick();
    check("arb_withdrawn_waitreq", 32'(avs_waitrequest), 32'd1);

    // Overlapping strobe is dropped and flagged; only one read happens.
    jtag_a(8'h30, 1'b0);
    jtag_n();
    jtag_n();
    check("err_set", 32'(monitor_error), 32'd1);
    wait_ready("err_rd_ready", 8);
    check("err_rd_mondreg", MonDReg, 32'h3030_3030);
    check("err_sticky", 32'(monitor_error), 32'd1);
    jtag_n();
    wait_ready("err_next_ready", 8);
    check("err_single_inc", MonDReg, 32'h3131_3131);
    jtag_a(8'hFF, 1'b0);
    check("err_cleared", 32'(monitor_error), 32'd0);

    // Address 0xFF wraps to 0x00 after a write.
    jtag_b(32'hFFAA_0055);
    tick();
    check("wrap_wr_addr", 32'(ram_addr), 32'hFF);
    tick();
    check("wrap_mem_ff", mem[8'hFF], 32'hFFAA_0055);
    jtag_n();
    tick();
    check("wrap_rd_addr", 32'(ram_addr), 32'h00);
    tick(2);
    check("wrap_rd_mondreg", MonDReg, 32'h0000_D000);

    // Reset in RD_WAIT: outputs return to reset values, MonDReg not loaded.
    jtag_a(8'h20, 1'b1);
    tick(2);
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_rdwait");
    reset = 1'b0;
    tick();

    // Reset during a JTAG write ACCESS: no RAM write lands, pending work is gone.
    jtag_a(8'h40, 1'b0);
    jtag_b(32'h9999_9999);
    tick();
    check("rstwr_c2_ram_wr", 32'(ram_wr), 32'd1);
    reset = 1'b1;
    tick();
    check("rstwr_ram_wr", 32'(ram_wr), 32'd0);
    check("rstwr_mem40", mem[8'h40], 32'h4040_4040);
    reset = 1'b0;
    tick(2);
    check("rstwr_ready", 32'(monitor_ready), 32'd1);
    check("rstwr_mem40_after", mem[8'h40], 32'h4040_4040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
